my_comparator_gate: RTL and testbench



---
 rtl/my_comparator_gate.sv | 92 +++++++++
 tb/tb_my_comparator_gate.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/my_comparator_gate.sv
// my_comparator_gate: registered 4-bit unsigned magnitude comparator.
// The compare core is built from gate primitives only; three flops hold the
// less / greater / equal flags so the outputs never see a combinational path
// from the operands.
module my_comparator_gate (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       A_It_B,
  output logic       A_gt_B,
  output logic       A_eq_B
);

  // Per-bit terms: equality, A-wins and B-wins at each bit position.
  wire [3:0] e;
  wire [3:0] g;
  wire [3:0] l;
  wire [3:0] na;
  wire [3:0] nb;

  // Prefix equality: pe[i] is 1 when every bit above i matches.
  // pe[3] is implicitly 1 (nothing above the MSB), so it is not built.
  wire [2:0] pe;

  // Priority-qualified terms; bit 3 needs no qualification.
  wire [3:0] gt_t;
  wire [3:0] lt_t;

  wire gt_c;
  wire lt_c;
  wire eq_c;

  logic lt_q, lt_d;
  logic gt_q, gt_d;
  logic eq_q, eq_d;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      xnor u_e  (e[gi],  A[gi],  B[gi]);
      not  u_na (na[gi], A[gi]);
      not  u_nb (nb[gi], B[gi]);
      and  u_g  (g[gi],  A[gi],  nb[gi]);
      and  u_l  (l[gi],  na[gi], B[gi]);
    end
  endgenerate

  // MSB-first prefix chain of bit equalities.
  assign pe[2] = e[3];
  and u_pe1 (pe[1], e[3],  e[2]);
  and u_pe0 (pe[0], pe[1], e[1]);

  // A lower bit only decides when all higher bits are equal.
  assign gt_t[3] = g[3];
  assign lt_t[3] = l[3];
  generate
    for (gi = 0; gi < 3; gi++) begin : g_term
      and u_gt (gt_t[gi], pe[gi], g[gi]);
      and u_lt (lt_t[gi], pe[gi], l[gi]);
    end
  endgenerate

  or  u_gt_or (gt_c, gt_t[3], gt_t[2], gt_t[1], gt_t[0]);
  or  u_lt_or (lt_c, lt_t[3], lt_t[2], lt_t[1], lt_t[0]);
  and u_eq    (eq_c, pe[0], e[0]);

  // Next-state is simply the current comparison result.
  always_comb begin
    lt_d = lt_c;
    gt_d = gt_c;
    eq_d = eq_c;
  end

  // Result flops; reset forces the "no result" all-zero state.
  always_ff @(posedge clk) begin
    if (reset) begin
      lt_q <= 1'b0;
      gt_q <= 1'b0;
      eq_q <= 1'b0;
    end else begin
      lt_q <= lt_d;
      gt_q <= gt_d;
      eq_q <= eq_d;
    end
  end

  assign A_It_B = lt_q;
  assign A_gt_B = gt_q;
  assign A_eq_B = eq_q;

endmodule

// File: tb/tb_my_comparator_gate.sv
// Bench for my_comparator_gate: directed table, MSB dominance, mid-stream
// reset, mid-cycle operand change, exhaustive sweep and a random burst,
// all checked against an arithmetic reference model.
module tb_my_comparator_gate;

  logic       clk = 1'b0;
  logic       rst_drv;
  logic [3:0] a_drv;
  logic [3:0] b_drv;
  logic       lt_o, gt_o, eq_o;

  int n_checks = 0;
  int n_fail   = 0;

  my_comparator_gate dut (
    .clk    (clk),
    .reset  (rst_drv),
    .A      (a_drv),
    .B      (b_drv),
    .A_It_B (lt_o),
    .A_gt_B (gt_o),
    .A_eq_B (eq_o)
  );

  always #5 clk = ~clk;

  // Reference model: result of the pair seen at the last rising edge,
  // computed with plain integer relations. Bit order {lt, gt, eq}.
  logic [2:0] exp_q     = 3'b000;
  logic       started_q = 1'b0;
  logic       valid_q   = 1'b0;

  always @(posedge clk) begin
    started_q <= 1'b1;
    if (rst_drv) begin
      exp_q   <= 3'b000;
      valid_q <= 1'b0;
    end else begin
      exp_q   <= {(int'(a_drv) < int'(b_drv)), (int'(a_drv) > int'(b_drv)),
                  (int'(a_drv) == int'(b_drv))};
      valid_q <= 1'b1;
    end
  end

  // Every-cycle compare against the model, plus the one-hot invariant.
  always @(negedge clk) begin
    if (started_q) begin
      n_checks++;
      if ({lt_o, gt_o, eq_o} !== exp_q) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: got lt/gt/eq=%b want %b", $time,
                 {lt_o, gt_o, eq_o}, exp_q);
      end
      if (valid_q) begin
        n_checks++;
        if (!$onehot({lt_o, gt_o, eq_o})) begin
          n_fail++;
          $display("FAIL onehot t=%0t: got lt/gt/eq=%b want exactly one set",
                   $time, {lt_o, gt_o, eq_o});
        end
      end
    end
  end

  // Hand-computed literal expectation.
  task automatic check_lit(input string name, input logic [2:0] want);
    n_checks++;
    if ({lt_o, gt_o, eq_o} !== want) begin
      n_fail++;
      $display("FAIL %s: got lt/gt/eq=%b want %b", name, {lt_o, gt_o, eq_o}, want);
    end else begin
      $display("txn %s: lt/gt/eq=%b", name, {lt_o, gt_o, eq_o});
    end
  endtask

  // Directed table: operands, reset, expected {lt,gt,eq} one cycle later.
  localparam int ND = 10;
  logic [3:0] d_a   [ND] = '{4'h0, 4'hF, 4'hA, 4'h0, 4'h9, 4'h9, 4'h7, 4'h9, 4'h8, 4'h7};
  logic [3:0] d_b   [ND] = '{4'h1, 4'h3, 4'hB, 4'h0, 4'h9, 4'h9, 4'hD, 4'h9, 4'h7, 4'h8};
  logic       d_r   [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [2:0] d_exp [ND] = '{3'b100, 3'b010, 3'b100, 3'b001, 3'b000,
                             3'b001, 3'b100, 3'b001, 3'b010, 3'b100};

  initial begin
    rst_drv = 1'b1;
    a_drv   = 4'hF;
    b_drv   = 4'h3;

    // Reset held over two edges, then released.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_lit("reset_hold", 3'b000);
    rst_drv = 1'b0;
    @(negedge clk);
    check_lit("reset_release_F_3", 3'b010);

    // Directed sequence, back to back, including a one-cycle reset pulse.
    for (int i = 0; i < ND; i++) begin
      @(negedge clk);
      if (i > 0) check_lit($sformatf("dir%0d_%h_%h_r%0d", i - 1, d_a[i-1], d_b[i-1], d_r[i-1]), d_exp[i-1]);
      a_drv   = d_a[i];
      b_drv   = d_b[i];
      rst_drv = d_r[i];
    end
    @(negedge clk);
    check_lit($sformatf("dir%0d_%h_%h_r%0d", ND - 1, d_a[ND-1], d_b[ND-1], d_r[ND-1]), d_exp[ND-1]);

    // Mid-cycle operand change only takes effect at the next rising edge.
    a_drv = 4'h3;
    b_drv = 4'h3;
    @(posedge clk);
    #2;
    a_drv = 4'h4;
    @(negedge clk);
    check_lit("latency_hold_3_3", 3'b001);
    @(negedge clk);
    check_lit("latency_next_4_3", 3'b010);

    // Exhaustive sweep, one pair per cycle; checked by the model process.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        @(negedge clk);
        a_drv = 4'(a);
        b_drv = 4'(b);
      end
    end

    // Random burst with occasional reset pulses.
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      a_drv   = 4'($urandom_range(0, 15));
      b_drv   = 4'($urandom_range(0, 15));
      rst_drv = ($urandom_range(0, 19) == 0);
    end
    @(negedge clk);
    rst_drv = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
